// File: rtl/game_session_ctrl.sv
// Game session controller: coin-insertion timeout, play-session timer,
// banked-coin and refund counters. All outputs are registered.
module game_session_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 20,
  parameter int unsigned GAME_CYCLES    = 100,
  parameter int unsigned COINS_PER_GAME = 3,
  parameter int unsigned BANK_W         = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              timer_en,
  input  logic              reset_timer,
  input  logic              game_start,
  input  logic              eat_coins,
  input  logic              spit_coin,
  input  logic              player_done,
  output logic              timer_finish,
  output logic              game_finish,
  output logic              game_active,
  output logic [7:0]        time_left,
  output logic [BANK_W-1:0] coins_banked,
  output logic [7:0]        refund_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_TIMEOUT,
    S_PLAYING,
    S_FINISH
  } state_t;

  localparam logic [7:0]      ARM_LOAD  = 8'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]      GAME_LOAD = 8'(GAME_CYCLES - 1);
  localparam logic [BANK_W:0] COIN_INC  = (BANK_W + 1)'(COINS_PER_GAME);

  state_t      state;
  logic [7:0]  count;
  logic [BANK_W:0] bank_sum;

  // Session FSM: state, shared down-counter and all registered status outputs.
  // time_left mirrors the counter only in ARMED/PLAYING and is zeroed on exit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      count        <= '0;
      timer_finish <= 1'b0;
      game_finish  <= 1'b0;
      game_active  <= 1'b0;
      time_left    <= '0;
    end else begin
      timer_finish <= 1'b0;
      game_finish  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (game_start) begin
            state       <= S_PLAYING;
            count       <= GAME_LOAD;
            time_left   <= GAME_LOAD;
            game_active <= 1'b1;
          end else if (timer_en) begin
            state     <= S_ARMED;
            count     <= ARM_LOAD;
            time_left <= ARM_LOAD;
          end
        end

        S_ARMED: begin
          if (game_start) begin
            state       <= S_PLAYING;
            count       <= GAME_LOAD;
            time_left   <= GAME_LOAD;
            game_active <= 1'b1;
          end else if (reset_timer) begin
            state     <= S_IDLE;
            count     <= '0;
            time_left <= '0;
          end else if (count == '0) begin
            state        <= S_TIMEOUT;
            timer_finish <= 1'b1;
            time_left    <= '0;
          end else begin
            count     <= count - 8'd1;
            time_left <= count - 8'd1;
          end
        end

        S_TIMEOUT: begin
          state <= S_IDLE;
        end

        S_PLAYING: begin
          if (player_done || count == '0) begin
            state       <= S_FINISH;
            count       <= '0;
            time_left   <= '0;
            game_active <= 1'b0;
            game_finish <= 1'b1;
          end else begin
            count     <= count - 8'd1;
            time_left <= count - 8'd1;
          end
        end

        S_FINISH: begin
          state <= S_IDLE;
        end

        default: begin
          state       <= S_IDLE;
          count       <= '0;
          time_left   <= '0;
          game_active <= 1'b0;
        end
      endcase
    end
  end

  // Extended-width sum; the carry bit flags that the bank would overflow.
  always_comb begin
    bank_sum = {1'b0, coins_banked} + COIN_INC;
  end

  // Banked-coin counter, saturating at all-ones, independent of FSM state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      coins_banked <= '0;
    end else if (eat_coins) begin
      coins_banked <= bank_sum[BANK_W] ? '1 : bank_sum[BANK_W-1:0];
    end
  end

  // Refund event counter, wraps naturally at 8 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      refund_count <= '0;
    end else if (spit_coin) begin
      refund_count <= refund_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_game_session_ctrl.sv
// Self-checking bench for game_session_ctrl: remaining-time model compared
// every cycle, plus hand-computed literal expectations on directed sequences.
module tb_game_session_ctrl;

  localparam int T_CYC  = 4;
  localparam int G_CYC  = 6;
  localparam int COINS  = 3;
  localparam int BW     = 4;
  localparam int BMAX   = (1 << BW) - 1;

  localparam logic [5:0] NONE = 6'b000000;
  localparam logic [5:0] TE   = 6'b100000;
  localparam logic [5:0] RT   = 6'b010000;
  localparam logic [5:0] GS   = 6'b001000;
  localparam logic [5:0] EC   = 6'b000100;
  localparam logic [5:0] SC   = 6'b000010;
  localparam logic [5:0] PD   = 6'b000001;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [5:0]    in_vec = '0;
  logic          timer_finish, game_finish, game_active;
  logic [7:0]    time_left, refund_count;
  logic [BW-1:0] coins_banked;

  int errors = 0;
  int checks = 0;

  // Model: remaining cycles of each timer (-1 = not running) and pending pulses.
  int m_arm = -1;
  int m_play = -1;
  int m_tf = 0;
  int m_gf = 0;
  int m_coins = 0;
  int m_refund = 0;

  int exp_c[6] = '{3, 6, 9, 12, 15, 15};

  always #5 clk = ~clk;

  game_session_ctrl #(
    .TIMEOUT_CYCLES(T_CYC),
    .GAME_CYCLES(G_CYC),
    .COINS_PER_GAME(COINS),
    .BANK_W(BW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .timer_en(in_vec[5]),
    .reset_timer(in_vec[4]),
    .game_start(in_vec[3]),
    .eat_coins(in_vec[2]),
    .spit_coin(in_vec[1]),
    .player_done(in_vec[0]),
    .timer_finish(timer_finish),
    .game_finish(game_finish),
    .game_active(game_active),
    .time_left(time_left),
    .coins_banked(coins_banked),
    .refund_count(refund_count)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input logic [5:0] v);
    @(negedge clk);
    in_vec = v;
  endtask

  // Model update on every rising edge, then compare all outputs just after it.
  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        m_arm = -1; m_play = -1; m_tf = 0; m_gf = 0; m_coins = 0; m_refund = 0;
      end else begin
        if (in_vec[2]) m_coins = (m_coins + COINS > BMAX) ? BMAX : m_coins + COINS;
        if (in_vec[1]) m_refund = (m_refund + 1) % 256;
        if (m_tf != 0 || m_gf != 0) begin
          m_tf = 0;
          m_gf = 0;
        end else if (m_play >= 0) begin
          if (in_vec[0] || m_play == 0) begin
            m_play = -1;
            m_gf = 1;
          end else begin
            m_play--;
          end
        end else if (m_arm >= 0) begin
          if (in_vec[3]) begin
            m_arm = -1;
            m_play = G_CYC - 1;
          end else if (in_vec[4]) begin
            m_arm = -1;
          end else if (m_arm == 0) begin
            m_arm = -1;
            m_tf = 1;
          end else begin
            m_arm--;
          end
        end else if (in_vec[3]) begin
          m_play = G_CYC - 1;
        end else if (in_vec[5]) begin
          m_arm = T_CYC - 1;
        end
      end
      #1;
      chk("m_time_left", int'(time_left),
          (m_play >= 0) ? m_play : ((m_arm >= 0) ? m_arm : 0));
      chk("m_game_active", int'(game_active), (m_play >= 0) ? 1 : 0);
      chk("m_timer_finish", int'(timer_finish), m_tf);
      chk("m_game_finish", int'(game_finish), m_gf);
      chk("m_coins_banked", int'(coins_banked), m_coins);
      chk("m_refund_count", int'(refund_count), m_refund);
      chk("m_finish_excl", int'(timer_finish & game_finish), 0);
    end
  end

  // Directed sequences with literal expectations.
  initial begin
    #1;
    chk("rst_time_left", int'(time_left), 0);
    chk("rst_game_active", int'(game_active), 0);
    chk("rst_coins", int'(coins_banked), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Timeout countdown 3,2,1,0 then one-cycle timer_finish.
    tick(TE);
    tick(NONE); chk("to_tl3", int'(time_left), 3);
    tick(NONE); chk("to_tl2", int'(time_left), 2);
    tick(NONE); chk("to_tl1", int'(time_left), 1);
    tick(NONE); chk("to_tl0", int'(time_left), 0);
    tick(NONE); chk("to_tf1", int'(timer_finish), 1);
    tick(NONE); chk("to_tf0", int'(timer_finish), 0);
    chk("to_idle_tl", int'(time_left), 0);

    // timer_en while armed does not reload.
    tick(TE);
    tick(TE);
    tick(TE); chk("rearm_tl2", int'(time_left), 2);
    repeat (5) tick(NONE);

    // Abort two cycles after arming.
    tick(TE);
    tick(NONE);
    tick(RT); chk("abort_tl2", int'(time_left), 2);
    tick(NONE); chk("abort_tl0", int'(time_left), 0);
    chk("abort_tf0", int'(timer_finish), 0);
    repeat (4) tick(NONE);

    // Full session started from ARMED, coins eaten on the same cycle.
    tick(TE);
    tick(GS | EC);
    for (int k = 5; k >= 0; k--) begin
      tick(NONE);
      chk("full_active", int'(game_active), 1);
      chk("full_tl", int'(time_left), k);
    end
    tick(NONE);
    chk("full_gf", int'(game_finish), 1);
    chk("full_ga0", int'(game_active), 0);
    chk("full_coins", int'(coins_banked), 3);
    tick(NONE); chk("full_gf_off", int'(game_finish), 0);

    // Early end on the second playing cycle.
    tick(GS);
    tick(NONE); chk("early_tl5", int'(time_left), 5);
    tick(PD);   chk("early_tl4", int'(time_left), 4);
    tick(NONE);
    chk("early_gf", int'(game_finish), 1);
    chk("early_ga0", int'(game_active), 0);
    tick(NONE);

    // Asynchronous reset mid-session, then start on first edge after release.
    tick(GS);
    tick(NONE);
    tick(NONE);
    #2 rst = 1'b1;
    #1;
    chk("arst_ga", int'(game_active), 0);
    chk("arst_tl", int'(time_left), 0);
    chk("arst_gf", int'(game_finish), 0);
    chk("arst_coins", int'(coins_banked), 0);
    @(negedge clk);
    rst = 1'b0;
    in_vec = GS;
    tick(NONE);
    chk("post_rst_ga", int'(game_active), 1);
    chk("post_rst_tl", int'(time_left), 5);
    tick(PD);
    tick(NONE); chk("post_rst_gf", int'(game_finish), 1);
    tick(NONE);

    // Coin saturation.
    for (int i = 0; i < 6; i++) begin
      tick(EC);
      tick(NONE);
      chk("sat_coins", int'(coins_banked), exp_c[i]);
    end

    // game_start beats timer_en in IDLE; control inputs ignored while playing.
    tick(GS | TE);
    tick(TE | RT | GS);
    chk("prio_ga", int'(game_active), 1);
    chk("prio_tl5", int'(time_left), 5);
    tick(NONE); chk("prio_tl4", int'(time_left), 4);
    tick(PD);
    tick(NONE); chk("prio_gf", int'(game_finish), 1);
    tick(NONE);

    // Simultaneous eat/spit, then refund wrap.
    tick(EC | SC);
    tick(NONE);
    chk("both_coins", int'(coins_banked), 15);
    chk("both_refund", int'(refund_count), 1);
    for (int i = 0; i < 255; i++) tick(SC);
    tick(NONE); chk("refund_wrap", int'(refund_count), 0);
    repeat (3) tick(NONE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
